// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: pointer width convention and Gray/binary conversion.
// Reused by both the write-side full and the read-side empty generators.
package async_fifo_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    // Pointers carry one extra wrap bit beyond the address.
    function automatic int unsigned ptr_w(input int unsigned addrsize);
        return addrsize + 1;
    endfunction

    // Works for any width up to MAX_PTR_W when the operand is zero-extended.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < int'(MAX_PTR_W); i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_wptr_full_gray_to_binary.sv
// XOR-prefix Gray-to-binary converter for the synchronized read pointer.
module gray_to_binary #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer, full/almost-full, level and overflow generator for the async FIFO.
// Define WOVF_STICKY_EN to make wovf sticky until wovf_clr.
module async_fifo_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                wr_clk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int unsigned PTR_W = ptr_w(ADDRSIZE);

    logic [PTR_W-1:0] wbin_q, wbin_next;
    logic [PTR_W-1:0] wptr_q, wgray_next;
    logic [PTR_W-1:0] rbin, level_next, full_cmp;
    logic             wfull_q, wfull_d;
    logic             wafull_q, wafull_d;
    logic [PTR_W-1:0] wlevel_q;
    logic             wovf_q, wovf_d;
    logic             ovf_set;

    gray_to_binary #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    always_comb begin
        wen        = winc & ~wfull_q;
        wbin_next  = wbin_q + {{(PTR_W-1){1'b0}}, wen};
        wgray_next = PTR_W'(bin2gray(MAX_PTR_W'(wbin_next)));
        // Full when the Gray pointers differ only in their top two bits.
        full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        wfull_d    = (wgray_next == full_cmp);
        level_next = wbin_next - rbin;
        wafull_d   = (MAX_PTR_W'(level_next) >= AFULL_THRESH);
        ovf_set    = winc & wfull_q;
    end

`ifdef WOVF_STICKY_EN
    always_comb begin
        wovf_d = wovf_q;
        if (ovf_set) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end
`else
    logic unused_wovf_clr;
    assign unused_wovf_clr = wovf_clr;

    always_comb begin
        wovf_d = ovf_set;
    end
`endif

    always_ff @(posedge wr_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_next;
            wptr_q   <= wgray_next;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= level_next;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign wovf         = wovf_q;

endmodule
